// File: rtl/clock_ctrl_pkg.sv
// Shared types and helpers for the CPU clock-control front-end.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  localparam int unsigned  DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned  CNT_W_DEF           = 20;
  localparam logic [7:0]   RATIO_RESET_DEF     = 8'd4;

  // Selectors 0..7 give a power-of-two ratio; anything larger saturates.
  function automatic logic [7:0] decode_ratio(input logic [3:0] sel);
    logic [7:0] r;
    if (sel[3]) r = 8'hFF;
    else        r = 8'd1 << sel[2:0];
    return r;
  endfunction

endpackage

// File: rtl/clock_control_debounce_sync.sv
// One pushbutton: 2-flop synchroniser, hold-time debounce and a registered
// one-cycle pulse on each accepted press (stable 1->0).
module debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             press_q;

  // A new level is accepted only after it has differed from the stable one
  // for DEBOUNCE_CYCLES consecutive cycles; any return clears the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      cnt_q        <= '0;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= key_ni;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_dly_q & ~stable_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_control.sv
// Operator front-end for the CPU clock tree: RUN/HALT/STEP control from two
// debounced keys, plus a divide ratio that is frozen while the CPU runs.
module clock_control
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter logic [7:0]  RATIO_RESET     = RATIO_RESET_DEF
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       key_mode_n,
  input  logic       key_step_n,
  input  logic [3:0] sw_ratio,
  output logic [7:0] ratio,
  output logic       clk_enable,
  output logic       running
);

  logic       mode_evt, step_evt;
  state_e     state_q, state_d;
  logic       clk_en_q, clk_en_d;
  logic       running_q, running_d;
  logic [3:0] sw_s1_q, sw_s2_q;
  logic [7:0] ratio_q, ratio_d;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_mode_key (
    .clk_i  (clock_in),
    .rst_ni (reset_n),
    .key_ni (key_mode_n),
    .press_o(mode_evt)
  );

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_step_key (
    .clk_i  (clock_in),
    .rst_ni (reset_n),
    .key_ni (key_step_n),
    .press_o(step_evt)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) state_q <= HALT;
    else          state_q <= state_d;
  end

  // Mode wins over step in HALT; anything arriving during STEP is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALT: begin
        if (mode_evt)      state_d = RUN;
        else if (step_evt) state_d = STEP;
      end
      RUN:     if (mode_evt) state_d = HALT;
      STEP:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // Outputs are decoded from the next state so they align with the state register.
  always_comb begin
    clk_en_d  = (state_d == RUN) || (state_d == STEP);
    running_d = (state_d == RUN);
    ratio_d   = (state_q == HALT) ? decode_ratio(sw_s2_q) : ratio_q;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      ratio_q   <= RATIO_RESET;
      clk_en_q  <= 1'b0;
      running_q <= 1'b0;
    end else begin
      sw_s1_q   <= sw_ratio;
      sw_s2_q   <= sw_s1_q;
      ratio_q   <= ratio_d;
      clk_en_q  <= clk_en_d;
      running_q <= running_d;
    end
  end

  assign ratio      = ratio_q;
  assign clk_enable = clk_en_q;
  assign running    = running_q;

endmodule

// File: tb/tb_clock_control.sv
// Randomised and directed bench for clock_control against a behavioural model
// built from the operator-visible rules (hold-time debounce, RUN/HALT/STEP, ratio freeze).
module tb_clock_control;

  localparam int DC     = 4;
  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic       clock_in   = 1'b0;
  logic       reset_n    = 1'b0;
  logic       key_mode_n = 1'b1;
  logic       key_step_n = 1'b1;
  logic [3:0] sw_ratio   = 4'd0;
  logic [7:0] ratio;
  logic       clk_enable;
  logic       running;

  int totalChecks = 0;
  int badChecks   = 0;

  clock_control #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (20),
    .RATIO_RESET    (8'd4)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .key_mode_n(key_mode_n),
    .key_step_n(key_step_n),
    .sw_ratio  (sw_ratio),
    .ratio     (ratio),
    .clk_enable(clk_enable),
    .running   (running)
  );

  always #5 clock_in = ~clock_in;

  // Model state: raw key delay line, window of recent synced samples per key,
  // accepted level, event delay, operating mode and ratio.
  bit       rawD1 [2];
  bit       rawD2 [2];
  bit       stableM [2];
  bit       synWin [2][$];
  bit [1:0] evtPipe [2];
  int       modelMode;
  int       modelRatio;
  int       swD1, swD2;

  function automatic void resetModel();
    for (int k = 0; k < 2; k++) begin
      rawD1[k]   = 1'b1;
      rawD2[k]   = 1'b1;
      stableM[k] = 1'b1;
      synWin[k].delete();
      evtPipe[k] = 2'b00;
    end
    modelMode  = M_HALT;
    modelRatio = 4;
    swD1       = 0;
    swD2       = 0;
  endfunction

  initial resetModel();

  // Key accepted once the last DC synced samples all disagree with the
  // current level; the FSM sees the press two cycles after acceptance.
  always @(posedge clock_in or negedge reset_n) begin : model
    bit rawNow [2];
    bit fsmEvt [2];
    bit syn, fell, allDiffer;
    int prevMode;
    if (!reset_n) begin
      resetModel();
    end else begin
      rawNow[0] = key_mode_n;
      rawNow[1] = key_step_n;
      for (int k = 0; k < 2; k++) begin
        syn      = rawD2[k];
        rawD2[k] = rawD1[k];
        rawD1[k] = rawNow[k];
        synWin[k].push_back(syn);
        if (synWin[k].size() > DC) void'(synWin[k].pop_front());
        fell      = 1'b0;
        allDiffer = (synWin[k].size() == DC);
        foreach (synWin[k][i]) if (synWin[k][i] == stableM[k]) allDiffer = 1'b0;
        if (allDiffer) begin
          fell       = stableM[k] && !syn;
          stableM[k] = syn;
          synWin[k].delete();
        end
        fsmEvt[k]  = evtPipe[k][1];
        evtPipe[k] = {evtPipe[k][0], fell};
      end
      prevMode = modelMode;
      case (modelMode)
        M_HALT:  if (fsmEvt[0]) modelMode = M_RUN;
                 else if (fsmEvt[1]) modelMode = M_STEP;
        M_RUN:   if (fsmEvt[0]) modelMode = M_HALT;
        default: modelMode = M_HALT;
      endcase
      if (prevMode == M_HALT) modelRatio = (swD2 < 8) ? 2 ** swD2 : 255;
      swD2 = swD1;
      swD1 = int'(sw_ratio);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalChecks++;
    if (actual != expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock_in) begin
    checkOutput("model_ratio", int'(ratio), modelRatio);
    checkOutput("model_clk_enable", int'(clk_enable), (modelMode != M_HALT) ? 1 : 0);
    checkOutput("model_running", int'(running), (modelMode == M_RUN) ? 1 : 0);
  end

  task automatic applyStimulus(input logic modeN, input logic stepN, input logic [3:0] sw);
    key_mode_n = modeN;
    key_step_n = stepN;
    sw_ratio   = sw;
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  initial begin : stimulus
    int  holdLeft [2];
    logic lvl [2];
    logic [3:0] sw;
    int  pulses;

    $display("[TB] start");
    applyStimulus(1'b1, 1'b1, 4'd0);
    waitNeg(3);
    checkOutput("reset_ratio", int'(ratio), 4);
    checkOutput("reset_clk_enable", int'(clk_enable), 0);
    checkOutput("reset_running", int'(running), 0);
    reset_n = 1'b1;
    waitNeg(20);
    checkOutput("idle_running", int'(running), 0);
    checkOutput("idle_clk_enable", int'(clk_enable), 0);

    // Bounce shorter than the hold time
    applyStimulus(1'b0, 1'b1, 4'd0);
    waitNeg(3);
    applyStimulus(1'b1, 1'b1, 4'd0);
    waitNeg(15);
    checkOutput("bounce_running", int'(running), 0);

    // Run toggle
    applyStimulus(1'b0, 1'b1, 4'd0);
    waitNeg(7);
    checkOutput("run_c7_running", int'(running), 0);
    waitNeg(1);
    checkOutput("run_c8_running", int'(running), 1);
    checkOutput("run_c8_clk_enable", int'(clk_enable), 1);
    waitNeg(2);
    applyStimulus(1'b1, 1'b1, 4'd0);
    waitNeg(12);
    checkOutput("run_release_running", int'(running), 1);
    applyStimulus(1'b0, 1'b1, 4'd0);
    waitNeg(8);
    checkOutput("halt_c8_running", int'(running), 0);
    checkOutput("halt_c8_clk_enable", int'(clk_enable), 0);
    applyStimulus(1'b1, 1'b1, 4'd0);
    waitNeg(12);

    // Single step with a long hold
    applyStimulus(1'b1, 1'b0, 4'd0);
    pulses = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock_in);
      if (i == 8) checkOutput("step_c8_clk_enable", int'(clk_enable), 1);
      if (i == 9) checkOutput("step_c9_clk_enable", int'(clk_enable), 0);
      pulses += int'(clk_enable);
    end
    checkOutput("step_pulse_count", pulses, 1);
    checkOutput("step_running", int'(running), 0);
    applyStimulus(1'b1, 1'b1, 4'd0);
    waitNeg(12);

    // Ratio load in HALT, freeze in RUN
    applyStimulus(1'b1, 1'b1, 4'd3);
    waitNeg(2);
    checkOutput("ratio_c2", int'(ratio), 1);
    waitNeg(1);
    checkOutput("ratio_c3", int'(ratio), 8);
    applyStimulus(1'b0, 1'b1, 4'd3);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock_in);
      if (i == 10) applyStimulus(1'b0, 1'b1, 4'd9);
      if (i == 12) applyStimulus(1'b1, 1'b1, 4'd9);
    end
    checkOutput("ratio_frozen", int'(ratio), 8);
    checkOutput("ratio_frozen_running", int'(running), 1);
    applyStimulus(1'b0, 1'b1, 4'd9);
    waitNeg(12);
    checkOutput("ratio_after_halt", int'(ratio), 255);
    checkOutput("ratio_after_halt_running", int'(running), 0);
    applyStimulus(1'b1, 1'b1, 4'd2);
    waitNeg(12);

    // Simultaneous press: mode wins, no step pulse
    applyStimulus(1'b0, 1'b0, 4'd2);
    waitNeg(7);
    checkOutput("simul_c7_clk_enable", int'(clk_enable), 0);
    waitNeg(1);
    checkOutput("simul_c8_running", int'(running), 1);
    waitNeg(4);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_clk_enable", int'(clk_enable), 0);
    checkOutput("async_reset_running", int'(running), 0);
    checkOutput("async_reset_ratio", int'(ratio), 4);
    applyStimulus(1'b1, 1'b1, 4'd2);
    waitNeg(3);
    reset_n = 1'b1;
    waitNeg(10);
    checkOutput("post_reset_running", int'(running), 0);

    // Random keys with bounces and long holds, random switches, one mid-run reset
    lvl[0] = 1'b1;
    lvl[1] = 1'b1;
    holdLeft[0] = $urandom_range(1, 10);
    holdLeft[1] = $urandom_range(1, 10);
    sw = 4'd2;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock_in);
      for (int k = 0; k < 2; k++) begin
        if (holdLeft[k] == 0) begin
          lvl[k]      = ~lvl[k];
          holdLeft[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                    : int'($urandom_range(5, 30));
        end
        holdLeft[k]--;
      end
      if ($urandom_range(0, 39) == 0) sw = 4'($urandom_range(0, 15));
      applyStimulus(lvl[0], lvl[1], sw);
      if (c == 2500) #2 reset_n = 1'b0;
      if (c == 2503) #2 reset_n = 1'b1;
    end
    waitNeg(2);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
